clk_gen_param: RTL
==================

Name: clk_gen_param

Overview:
Parametrised clock/enable generator for the lab SoC top level. It runs off the single 100 MHz board clock and produces:
- a free-running divider bus;
- a periodic pixel enable (one cycle in every PIX_DIV);
- a CPU clock-enable whose source is selected at run time: fast tap, slow tap, debounced single-step button, or halt.

All outputs are single-clock-domain enables, not gated clocks. Downstream logic stays on clk_100mhz.

Parameters:
CNT_W, 32, width of the free-running clkdiv counter
PIX_DIV, 4, pixel enable period in clocks (>=2); 4 gives 25 MHz
FAST_BIT, 3, clkdiv tap used for CPU enable in mode 00
SLOW_BIT, 23, clkdiv tap used for CPU enable in mode 01 (FAST_BIT < SLOW_BIT < CNT_W)
DEB_CYC, 1000000, stable-sample count for button debounce (10 ms at 100 MHz)
DEB_W, 20, width of debounce counter (2^DEB_W > DEB_CYC)

Ports:
clk_100mhz  input  1  board clock; sole clock of the block
rst  input  1  asynchronous, active-high reset
mode  input  2  CPU enable source: 00 fast, 01 slow, 10 single-step, 11 halt
btn_step  input  1  raw, bouncy, asynchronous step button
clkdiv  output  CNT_W  free-running counter
pix_en  output  1  one-cycle pulse every PIX_DIV clocks
cpu_clk_en  output  1  one-cycle CPU advance pulse
btn_clean  output  1  debounced button level (for LEDs/debug)

Behaviour:
- Reset (async, active-high): clkdiv=0, pix_en=0, cpu_clk_en=0, btn_clean=0, pixel counter=0, debounce counter=0, step FSM=S_IDLE, mode register=00, tap history=0. All outputs are registered.
- clkdiv: increments by 1 every clock and wraps from all-ones to 0 with no flag.
- Pixel counter: counts 0..PIX_DIV-1, then wraps.
  - pix_en is registered high for exactly one cycle when the counter holds PIX_DIV-1.
  - With PIX_DIV=4, the first pix_en is high after the 4th rising edge following reset release, then every 4 cycles.
- Mode: registered once (mode_q).
  - A change takes effect the cycle after it is sampled.
  - cpu_clk_en is forced 0 during the cycle in which mode_q changes, so a mode switch never produces a spurious pulse.
- Mode 00 / 01: cpu_clk_en pulses for one cycle on each 0->1 transition of clkdiv[FAST_BIT] / clkdiv[SLOW_BIT], detected against that tap's previous-cycle value.
  - Period is 2^(tap+1) clocks.
  - The tap history register updates every cycle regardless of mode.
- Mode 11: cpu_clk_en held 0. Counters keep running.
- Debouncer, which runs in all modes:
  - btn_step passes through a 2-FF synchroniser.
  - When the synchronised level differs from btn_clean, the counter increments; when it equals btn_clean, the counter clears.
  - When the counter reaches DEB_CYC-1, btn_clean toggles and the counter clears.
  - Glitches shorter than DEB_CYC cycles are never seen on btn_clean.
- Step FSM, which advances only in mode 10:
  - S_IDLE: btn_clean=1 -> S_FIRE.
  - S_FIRE: cpu_clk_en=1 for one cycle -> S_WAIT_REL.
  - S_WAIT_REL: btn_clean=0 -> S_IDLE.
  - One press gives exactly one pulse, however long the button is held.
  - If mode_q leaves 10 in any state, the FSM returns to S_IDLE next cycle and no pulse is emitted.
  - On entering mode 10 with the button already held, the FSM goes S_IDLE->S_WAIT_REL directly with no pulse. A release followed by a new press is required.
- Latency: from btn_clean rising to cpu_clk_en is 2 cycles (S_IDLE->S_FIRE, then registered output).
- Reset mid-operation (including mid-debounce or in S_FIRE): immediate return to reset values. Any pending pulse is dropped.

Optional Feature:
CLK_GEN_STEP_CNT_EN
- Defined: adds output step_count [15:0]. It resets to 0, increments on every cycle with cpu_clk_en=1 in any mode, and wraps at 16'hFFFF->0. Used for 7-seg instruction-count display.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
Bench parameters: PIX_DIV=4, FAST_BIT=1, SLOW_BIT=3, DEB_CYC=8, CNT_W=8, DEB_W=4.
- Reset release, run 20 cycles -> clkdiv counts 0..19. pix_en is high on cycles 4,8,12,16,20 and low otherwise.
- mode=00, 32 cycles -> cpu_clk_en pulses every 4 cycles. Switch to 01 -> no pulse in the switch cycle, then pulses every 16 cycles.
- mode=10, btn_step held high 30 cycles -> btn_clean rises about 10 cycles after the press, exactly one cpu_clk_en pulse 2 cycles later, none while held. Release, then a second press -> exactly one more pulse.
- mode=10, btn_step toggling every 3 cycles for 40 cycles -> btn_clean stays 0 and cpu_clk_en stays 0.
- mode=11 for 64 cycles -> cpu_clk_en=0 throughout while clkdiv and pix_en continue. Assert rst while FSM is in S_WAIT_REL -> all outputs 0, FSM in S_IDLE.
- With CLK_GEN_STEP_CNT_EN defined, mode=00 for 40 cycles -> step_count=10. Preload near 16'hFFFF via a long run or force -> wraps to 0.

Source files
------------

// File: rtl/clk_gen_param.sv
// Clock-enable generator: free-running divider, pixel enable and a mode-selected CPU enable.
// Optional step_count output is compiled in when CLK_GEN_STEP_CNT_EN is defined.
module clk_gen_param #(
    parameter int CNT_W    = 32,
    parameter int PIX_DIV  = 4,
    parameter int FAST_BIT = 3,
    parameter int SLOW_BIT = 23,
    parameter int DEB_CYC  = 1000000,
    parameter int DEB_W    = 20
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             btn_step,
    output logic [CNT_W-1:0] clkdiv,
    output logic             pix_en,
    output logic             cpu_clk_en,
    output logic             btn_clean
`ifdef CLK_GEN_STEP_CNT_EN
    ,
    output logic [15:0]      step_count
`endif
);

    localparam int PIX_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    localparam logic [1:0] M_FAST = 2'b00;
    localparam logic [1:0] M_SLOW = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT_REL
    } step_state_t;

    logic [PIX_W-1:0] pix_cnt;
    logic [1:0]       mode_q;
    logic             was_step;
    logic [1:0]       tap_q;
    logic [1:0]       sync_q;
    logic [DEB_W-1:0] deb_cnt;
    step_state_t      state, state_nxt;
    logic             fire;
    logic             mode_chg;
    logic             rise_fast, rise_slow;
    logic             cpu_src;

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            clkdiv  <= '0;
            pix_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            clkdiv  <= clkdiv + CNT_W'(1);
            pix_en  <= (pix_cnt == PIX_LAST);
            pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + PIX_W'(1);
        end
    end

    // was_step marks that mode_q was already 10 last cycle, so a button held
    // while entering step mode is not mistaken for a fresh press.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            mode_q   <= M_FAST;
            was_step <= 1'b0;
            tap_q    <= '0;
        end else begin
            mode_q   <= mode;
            was_step <= (mode_q == M_STEP);
            tap_q    <= {clkdiv[SLOW_BIT], clkdiv[FAST_BIT]};
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            deb_cnt   <= '0;
            btn_clean <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_step};
            if (sync_q[1] == btn_clean) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt   <= '0;
                btn_clean <= ~btn_clean;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        if (mode_q != M_STEP) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (btn_clean) state_nxt = was_step ? S_FIRE : S_WAIT_REL;
                end
                S_FIRE: begin
                    fire      = 1'b1;
                    state_nxt = S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (!btn_clean) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // A pending mode change masks the pulse on the edge that loads mode_q.
    always_comb begin
        mode_chg  = (mode != mode_q);
        rise_fast = clkdiv[FAST_BIT] & ~tap_q[0];
        rise_slow = clkdiv[SLOW_BIT] & ~tap_q[1];
        cpu_src   = 1'b0;
        case (mode_q)
            M_FAST:  cpu_src = rise_fast;
            M_SLOW:  cpu_src = rise_slow;
            M_STEP:  cpu_src = fire;
            default: cpu_src = 1'b0;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) cpu_clk_en <= 1'b0;
        else     cpu_clk_en <= cpu_src & ~mode_chg;
    end

`ifdef CLK_GEN_STEP_CNT_EN
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst)             step_count <= '0;
        else if (cpu_clk_en) step_count <= step_count + 16'd1;
    end
`endif

endmodule
